// File: rtl/fwd_hazard_unit.sv
// Forwarding select, store-data select and load-use stall for the 5-stage RV32I pipe.
// Optional perf counters are built when HAZ_PERF_EN is defined.
module fwd_hazard_unit #(
    parameter int NUM_SRC   = 2,
    parameter int REG_IDX_W = 5,
    parameter int SEL_W     = 3,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pipe_advance,
    input  logic                           flush,
    input  logic                           id_valid,
    input  logic [NUM_SRC*REG_IDX_W-1:0]   id_rs_idx,
    input  logic [NUM_SRC-1:0]             id_rs_used,
    input  logic [REG_IDX_W-1:0]           id_rd,
    input  logic                           id_we,
    input  logic [2:0]                     id_kind,
    input  logic                           id_is_store,
    output logic [NUM_SRC*SEL_W-1:0]       ex_fwd_sel,
    output logic                           dcache_fwd_sel,
    output logic                           load_use_stall,
    output logic [CNT_W-1:0]               stall_cycles,
    output logic [CNT_W-1:0]               fwd_events
);

    localparam logic [2:0] K_ALU   = 3'd0;
    localparam logic [2:0] K_BR    = 3'd1;
    localparam logic [2:0] K_UIMM  = 3'd2;
    localparam logic [2:0] K_LOAD  = 3'd3;
    localparam logic [2:0] K_PC4   = 3'd4;

    typedef struct packed {
        logic                         valid;
        logic                         we;
        logic [REG_IDX_W-1:0]         rd;
        logic [2:0]                   kind;
        logic [NUM_SRC*REG_IDX_W-1:0] rs_idx;
        logic [NUM_SRC-1:0]           rs_used;
        logic                         is_store;
    } ex_rec_t;

    // MEM and WB only keep the fields their consumers still look at
    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
        logic [2:0]           kind;
        logic                 is_store;
        logic                 st_used;
        logic [REG_IDX_W-1:0] st_idx;
    } mem_rec_t;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
    } wb_rec_t;

    ex_rec_t  ex_q, ex_d;
    mem_rec_t mem_q, mem_d;
    wb_rec_t  wb_q, wb_d;

    logic              mem_wr;
    logic              wb_wr;
    logic              ex_ld_wr;
    logic [NUM_SRC-1:0] mem_hit;
    logic [NUM_SRC-1:0] wb_hit;
    logic [NUM_SRC-1:0] id_hit;
    logic              ld_hit;

    function automatic logic [SEL_W-1:0] kind_sel(input logic [2:0] kind);
        logic [SEL_W-1:0] s;
        unique case (kind)
            K_ALU:   s = SEL_W'(3'd1);
            K_BR:    s = SEL_W'(3'd2);
            K_UIMM:  s = SEL_W'(3'd5);
            K_LOAD:  s = SEL_W'(3'd4);
            K_PC4:   s = SEL_W'(3'd6);
            default: s = '0;
        endcase
        return s;
    endfunction

    assign mem_wr   = mem_q.valid && mem_q.we && (mem_q.rd != '0);
    assign wb_wr    = wb_q.valid && wb_q.we && (wb_q.rd != '0);
    assign ex_ld_wr = ex_q.valid && ex_q.we && (ex_q.rd != '0)
                      && (ex_q.kind == K_LOAD);

    always_comb begin
        mem_hit    = '0;
        wb_hit     = '0;
        id_hit     = '0;
        ex_fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            mem_hit[k] = ex_q.valid && ex_q.rs_used[k] && mem_wr
                && (mem_q.rd == ex_q.rs_idx[k*REG_IDX_W +: REG_IDX_W]);
            wb_hit[k]  = ex_q.valid && ex_q.rs_used[k] && wb_wr
                && (wb_q.rd == ex_q.rs_idx[k*REG_IDX_W +: REG_IDX_W]);
            id_hit[k]  = id_rs_used[k]
                && (id_rs_idx[k*REG_IDX_W +: REG_IDX_W] == ex_q.rd);
            if (mem_hit[k]) begin
                ex_fwd_sel[k*SEL_W +: SEL_W] = kind_sel(mem_q.kind);
            end else if (wb_hit[k]) begin
                ex_fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(3'd3);
            end
        end
    end

    assign load_use_stall = ex_ld_wr && id_valid && (|id_hit);
    assign ld_hit = (|mem_hit) && (mem_q.kind == K_LOAD);

    assign dcache_fwd_sel = mem_q.valid && mem_q.is_store && mem_q.st_used
                            && wb_wr && (wb_q.rd == mem_q.st_idx);

    always_comb begin
        ex_d          = '0;
        if (!(flush || load_use_stall)) begin
            ex_d.valid    = id_valid;
            ex_d.we       = id_we;
            ex_d.rd       = id_rd;
            ex_d.kind     = id_kind;
            ex_d.rs_idx   = id_rs_idx;
            ex_d.rs_used  = id_rs_used;
            ex_d.is_store = id_is_store;
        end
        mem_d.valid    = ex_q.valid;
        mem_d.we       = ex_q.we;
        mem_d.rd       = ex_q.rd;
        mem_d.kind     = ex_q.kind;
        mem_d.is_store = ex_q.is_store;
        mem_d.st_used  = ex_q.rs_used[1];
        mem_d.st_idx   = ex_q.rs_idx[REG_IDX_W +: REG_IDX_W];
        wb_d.valid     = mem_q.valid;
        wb_d.we        = mem_q.we;
        wb_d.rd        = mem_q.rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (pipe_advance) begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // A load in MEM feeding EX means the stall bubble was lost
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!ld_hit);
        end
    end

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] fwd_q, fwd_d;
    logic             any_fwd;

    assign any_fwd = ex_q.valid && (|ex_fwd_sel);

    always_comb begin
        stall_d = stall_q;
        fwd_d   = fwd_q;
        if (pipe_advance && load_use_stall && !(&stall_q)) begin
            stall_d = stall_q + 1'b1;
        end
        if (pipe_advance && any_fwd && !(&fwd_q)) begin
            fwd_d = fwd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            fwd_q   <= '0;
        end else begin
            stall_q <= stall_d;
            fwd_q   <= fwd_d;
        end
    end

    assign stall_cycles = stall_q;
    assign fwd_events   = fwd_q;
`else
    assign stall_cycles = '0;
    assign fwd_events   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed hazards then random traffic vs a model.
// Counter checks follow HAZ_PERF_EN.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst;
    logic        t_adv;
    logic        t_flush;
    logic        t_v;
    logic [4:0]  t_rs0, t_rs1;
    logic        t_u0, t_u1;
    logic [4:0]  t_rd;
    logic        t_we;
    logic [2:0]  t_kind;
    logic        t_st;

    logic [5:0]  ex_fwd_sel;
    logic        dcache_fwd_sel;
    logic        load_use_stall;
    logic [31:0] stall_cycles;
    logic [31:0] fwd_events;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(
        .NUM_SRC(2), .REG_IDX_W(5), .SEL_W(3), .CNT_W(32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pipe_advance   (t_adv),
        .flush          (t_flush),
        .id_valid       (t_v),
        .id_rs_idx      ({t_rs1, t_rs0}),
        .id_rs_used     ({t_u1, t_u0}),
        .id_rd          (t_rd),
        .id_we          (t_we),
        .id_kind        (t_kind),
        .id_is_store    (t_st),
        .ex_fwd_sel     (ex_fwd_sel),
        .dcache_fwd_sel (dcache_fwd_sel),
        .load_use_stall (load_use_stall),
        .stall_cycles   (stall_cycles),
        .fwd_events     (fwd_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [4:0] rd;
        logic [2:0] kind;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic       u0;
        logic       u1;
        logic       st;
    } mrec_t;

    mrec_t       mex, mmem, mwb;
    longint      m_stc, m_fwc;
    logic [2:0]  kmap [8];

    function automatic bit wr(mrec_t r);
        return r.valid && r.we && (r.rd != 5'd0);
    endfunction

    function automatic logic [4:0] sidx(mrec_t r, int k);
        return (k == 0) ? r.rs0 : r.rs1;
    endfunction

    function automatic bit sused(mrec_t r, int k);
        return (k == 0) ? r.u0 : r.u1;
    endfunction

    function automatic logic [2:0] e_sel(int k);
        if (!mex.valid || !sused(mex, k)) return 3'd0;
        if (wr(mmem) && mmem.rd == sidx(mex, k)) return kmap[mmem.kind];
        if (wr(mwb) && mwb.rd == sidx(mex, k)) return 3'd3;
        return 3'd0;
    endfunction

    function automatic bit e_stall();
        if (!(wr(mex) && mex.kind == 3'd3 && t_v)) return 1'b0;
        return (t_u0 && t_rs0 == mex.rd) || (t_u1 && t_rs1 == mex.rd);
    endfunction

    function automatic bit e_dc();
        return mmem.valid && mmem.st && mmem.u1 && wr(mwb)
               && mwb.rd == mmem.rs1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mex = '0;
        mmem = '0;
        mwb = '0;
        m_stc = 0;
        m_fwc = 0;
    endtask

    task automatic check_all();
        chk("sel0", 32'(ex_fwd_sel[2:0]), 32'(e_sel(0)));
        chk("sel1", 32'(ex_fwd_sel[5:3]), 32'(e_sel(1)));
        chk("stall", 32'(load_use_stall), 32'(e_stall()));
        chk("dcache", 32'(dcache_fwd_sel), 32'(e_dc()));
`ifdef HAZ_PERF_EN
        chk("stall_cnt", stall_cycles, 32'(m_stc));
        chk("fwd_cnt", fwd_events, 32'(m_fwc));
`else
        chk("stall_cnt", stall_cycles, 32'd0);
        chk("fwd_cnt", fwd_events, 32'd0);
`endif
    endtask

    task automatic step();
        bit    es;
        bit    af;
        mrec_t nx;
        #2;
        check_all();
        es = e_stall();
        af = mex.valid && (e_sel(0) != 0 || e_sel(1) != 0);
        nx = '{valid: t_v, we: t_we, rd: t_rd, kind: t_kind,
               rs0: t_rs0, rs1: t_rs1, u0: t_u0, u1: t_u1, st: t_st};
        @(posedge clk);
        if (t_adv) begin
            if (es && m_stc < 64'hFFFF_FFFF) m_stc++;
            if (af && m_fwc < 64'hFFFF_FFFF) m_fwc++;
            mwb  = mmem;
            mmem = mex;
            mex  = (t_flush || es) ? '0 : nx;
        end
        #1;
    endtask

    task automatic id(bit v, bit we, int rd, int kind,
                      int r0, bit u0, int r1, bit u1, bit st);
        t_v    = v;
        t_we   = we;
        t_rd   = 5'(rd);
        t_kind = 3'(kind);
        t_rs0  = 5'(r0);
        t_u0   = u0;
        t_rs1  = 5'(r1);
        t_u1   = u1;
        t_st   = st;
    endtask

    task automatic nop();
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd0(int r);
        id(1, 0, 0, 0, r, 1, 0, 0, 0);
    endtask

    initial begin
        kmap[0] = 3'd1; kmap[1] = 3'd2; kmap[2] = 3'd5; kmap[3] = 3'd4;
        kmap[4] = 3'd6; kmap[5] = 3'd0; kmap[6] = 3'd0; kmap[7] = 3'd0;
        model_clear();
        t_adv = 1'b1;
        t_flush = 1'b0;
        nop();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        chk("rst_sel", 32'(ex_fwd_sel), 32'd0);
        chk("rst_stall", 32'(load_use_stall), 32'd0);
        chk("rst_dc", 32'(dcache_fwd_sel), 32'd0);
        check_all();
        #9 rst = 1'b1;

        id(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
        rd0(5); step();
        chk("b2b_sel", 32'(ex_fwd_sel[2:0]), 32'd1);
        chk("b2b_stall", 32'(load_use_stall), 32'd0);

        id(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
        nop(); step();
        rd0(5); step();
        chk("two_apart", 32'(ex_fwd_sel[2:0]), 32'd3);

        id(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
        id(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
        rd0(5); step();
        chk("mem_prio", 32'(ex_fwd_sel[2:0]), 32'd1);

        id(1, 1, 7, 3, 0, 0, 0, 0, 0); step();
        rd0(7);
        #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
        step();
        chk("lu_bubble", 32'(load_use_stall), 32'd0);
        step();
        chk("lu_sel", 32'(ex_fwd_sel[2:0]), 32'd3);
`ifdef HAZ_PERF_EN
        chk("lu_cnt", stall_cycles, 32'd1);
`else
        chk("lu_cnt", stall_cycles, 32'd0);
`endif

        id(1, 1, 0, 0, 0, 0, 0, 0, 0); step();
        rd0(0); step();
        chk("x0_sel", 32'(ex_fwd_sel[2:0]), 32'd0);
        id(1, 1, 0, 3, 0, 0, 0, 0, 0); step();
        rd0(0);
        #1 chk("x0_stall", 32'(load_use_stall), 32'd0);
        step();

        id(1, 1, 3, 2, 0, 0, 0, 0, 0); step();
        rd0(3); step();
        chk("uimm_sel", 32'(ex_fwd_sel[2:0]), 32'd5);

        id(1, 1, 4, 4, 0, 0, 0, 0, 0); step();
        id(1, 0, 0, 0, 0, 0, 4, 1, 0); step();
        chk("pc4_sel", 32'(ex_fwd_sel[5:3]), 32'd6);

        id(1, 1, 9, 0, 0, 0, 0, 0, 0); step();
        id(1, 0, 0, 0, 1, 1, 9, 1, 1); step();
        nop(); step();
        chk("st_fwd", 32'(dcache_fwd_sel), 32'd1);

        id(1, 1, 6, 3, 0, 0, 0, 0, 0); step();
        rd0(6);
        t_adv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_stall", 32'(load_use_stall), 32'd1);
        end
        t_adv = 1'b1;
        step();
        step();
        chk("hold_sel", 32'(ex_fwd_sel[2:0]), 32'd3);

        id(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
        rd0(5);
        t_flush = 1'b1;
        step();
        t_flush = 1'b0;
        chk("flush_sel", 32'(ex_fwd_sel), 32'd0);

        id(1, 1, 8, 3, 0, 0, 0, 0, 0); step();
        rd0(8);
        t_flush = 1'b1;
        step();
        t_flush = 1'b0;
        step();

        id(1, 1, 5, 0, 0, 0, 0, 0, 0); step();
        rd0(5); step();
        chk("pre_rst", 32'(ex_fwd_sel[2:0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(ex_fwd_sel), 32'd0);
        chk("mid_rst_dc", 32'(dcache_fwd_sel), 32'd0);
        chk("mid_rst_stc", stall_cycles, 32'd0);
        chk("mid_rst_fwc", fwd_events, 32'd0);
        model_clear();
        check_all();
        #1 rst = 1'b1;
        rd0(5); step();
        chk("post_rst", 32'(ex_fwd_sel[2:0]), 32'd0);

        for (int i = 0; i < 500; i++) begin
            id($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3), $urandom_range(0, 4),
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3) == 0);
            t_adv   = $urandom_range(0, 9) < 8;
            t_flush = $urandom_range(0, 9) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard controller for the 5-stage RV32I pipeline. Replaces the fixed per-operand forwarding select logic.
- Keeps its own EX/MEM/WB writer scoreboard, advanced in lock-step with the pipeline registers.
- Generates N operand forwarding selects for the EX stage, the dcache store-data select for MEM, and the load-use stall/bubble.
- Sits beside the datapath. Its outputs drive the EX operand muxes, the dcache write-data mux and the IF/ID hold logic.

Parameters:
NUM_SRC, 2, source operands tracked per instruction; source 1 is the store-data operand.
REG_IDX_W, 5, register index width.
SEL_W, 3, forwarding select width per source.
CNT_W, 32, performance counter width (optional feature only).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
pipe_advance  in  1  all pipeline registers load this cycle
flush  in  1  ID instruction is wrong-path; sampled only when pipe_advance=1
id_valid  in  1  ID holds a real instruction
id_rs_idx  in  NUM_SRC*REG_IDX_W  source indices, source k in bits [k*REG_IDX_W +: REG_IDX_W]
id_rs_used  in  NUM_SRC  source k is actually read
id_rd  in  REG_IDX_W  destination index
id_we  in  1  writes the register file
id_kind  in  3  producer kind: 0 ALU, 1 BR_EN, 2 U_IMM, 3 LOAD, 4 PC_PLUS4
id_is_store  in  1  ID instruction is a store
ex_fwd_sel  out  NUM_SRC*SEL_W  per-source select for the EX operand mux
dcache_fwd_sel  out  1  0 use rs2 from the pipe, 1 use regfilemux_out
load_use_stall  out  1  hold IF/ID this cycle
stall_cycles  out  CNT_W  performance counter
fwd_events  out  CNT_W  performance counter

Behaviour:
- Scoreboard: three records ex_r, mem_r, wb_r. Each holds {valid, we, rd, kind, rs_idx, rs_used, is_store}.
- Reset (rst=0, asynchronous): all records invalid. All outputs 0.
- Records change only on a clk edge with pipe_advance=1:
  - wb_r <= mem_r; mem_r <= ex_r.
  - ex_r <= bubble (valid=0) if flush=1 or load_use_stall=1.
  - Otherwise ex_r <= ID inputs, with valid=id_valid.
- When pipe_advance=0, all records hold. flush is ignored in that cycle.
- A record is a writer if valid && we && rd!=0. Register x0 never forwards and never stalls.
- ex_fwd_sel, source k (combinational from ex_r, mem_r, wb_r):
  - If ex_r is invalid or the source is unused, select 000.
  - Else if mem_r is a writer with rd == source index (MEM has priority), select by mem_r.kind: ALU 001, BR_EN 010, U_IMM 101, PC_PLUS4 110, LOAD 100.
  - Else if wb_r is a writer with a match, select 011 (regfilemux_out).
  - Else select 000.
  - LOAD in MEM matching EX is unreachable because of the stall below. A simulation assertion flags it.
- load_use_stall (combinational) = ex_r is a LOAD writer && id_valid && any used ID source matches ex_r.rd.
  - Asserted for exactly one advancing cycle per hazard: the bubble resolves it.
  - With pipe_advance=0 it stays asserted without changing state.
- dcache_fwd_sel = mem_r.valid && mem_r.is_store && mem_r.rs_used[1] && wb_r is a writer && wb_r.rd == mem_r source-1 index.
- Simultaneous flush and load_use_stall: a single bubble is inserted. load_use_stall is still driven out; upstream gives flush priority.
- Reset in mid-operation clears the scoreboard immediately; the first cycle after release behaves as an empty pipeline.

Optional Feature:
HAZ_PERF_EN
- Defined:
  - stall_cycles increments on each clk edge where load_use_stall && pipe_advance.
  - fwd_events increments by 1 on each advancing edge where any ex_fwd_sel is nonzero and ex_r is valid.
  - Both saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Back-to-back dependency: ALU writes x5; next instruction reads x5 as source 0 -> ex_fwd_sel[2:0]=001 in its EX cycle, load_use_stall=0.
- Two-apart dependency: ALU x5, NOP, reader of x5 -> ex_fwd_sel=011. Same but the younger writer also targets x5 -> 001 (MEM has priority).
- Load-use: LOAD x7, then reader of x7 -> load_use_stall=1 for one advancing cycle and a bubble enters EX. Next cycle ex_fwd_sel=011; with HAZ_PERF_EN, stall_cycles=1.
- Writer targets x0, reader uses x0 -> ex_fwd_sel=000, no stall. U_IMM writer x3 followed by reader of x3 -> 101. PC_PLUS4 writer -> 110.
- Store forwarding: ALU x9, then SW with rs2=x9 one slot behind (MEM/WB overlap) -> dcache_fwd_sel=1 during the store's MEM cycle.
- Hold/flush/reset: pipe_advance=0 for 3 cycles keeps the selects and stall stable. flush with advance gives ex_r invalid, so selects are 000 next cycle. rst low mid-stream clears all outputs to 0 asynchronously.
